// File: rtl/rob_complete_arbiter.sv
// rob_complete_arbiter
// Merges result writebacks from NUM_REQ functional units onto the three
// registered ROB completion ports. Up to three grants per cycle are made under
// rotating round-robin priority. A request whose ROB index collides with an
// already-granted request in the same cycle is skipped, and a sticky error
// flag is raised.
module rob_complete_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 32,
  parameter int PC_SIZE   = 32,
  parameter int ROB_SIZE  = 16,
  localparam int IDXW     = $clog2(ROB_SIZE)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*IDXW-1:0]        req_indx_i,
  input  logic [NUM_REQ*PC_SIZE-1:0]     req_pc_i,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_val_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           en_complete_instr0_o,
  output logic                           en_complete_instr1_o,
  output logic                           en_complete_instr2_o,
  output logic [IDXW-1:0]                complete_indx0_o,
  output logic [IDXW-1:0]                complete_indx1_o,
  output logic [IDXW-1:0]                complete_indx2_o,
  output logic [PC_SIZE-1:0]             complete_pc0_o,
  output logic [PC_SIZE-1:0]             complete_pc1_o,
  output logic [PC_SIZE-1:0]             complete_pc2_o,
  output logic [WORD_SIZE-1:0]           complete_val0_o,
  output logic [WORD_SIZE-1:0]           complete_val1_o,
  output logic [WORD_SIZE-1:0]           complete_val2_o,
  output logic                           dup_err_o
);

  localparam int PTRW  = $clog2(NUM_REQ);
  localparam int NPORT = 3;

  // Arbitration state and registered ROB ports.
  logic [PTRW-1:0]      r_rr_ptr;
  logic [NPORT-1:0]     r_en;
  logic [IDXW-1:0]      r_indx [NPORT];
  logic [PC_SIZE-1:0]   r_pc   [NPORT];
  logic [WORD_SIZE-1:0] r_val  [NPORT];
  logic                 r_dup_err;

  // Combinational arbitration results.
  logic [NUM_REQ-1:0]   w_ready;
  logic [NPORT-1:0]     w_slot_en;
  logic [PTRW-1:0]      w_sel  [NPORT];
  logic [IDXW-1:0]      w_gidx [NPORT];
  logic [1:0]           w_n;
  logic [PTRW:0]        w_scan;
  logic [PTRW-1:0]      w_k;
  logic [IDXW-1:0]      w_cand;
  logic                 w_hit;
  logic                 w_dup;
  logic [PTRW-1:0]      w_last;
  logic [PTRW-1:0]      w_next_ptr;

  // Scan requesters from rr_ptr, granting the first three valid, non-colliding ones in port order.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    w_ready   = '0;
    w_slot_en = '0;
    w_n       = 2'd0;
    w_scan    = '0;
    w_k       = '0;
    w_cand    = '0;
    w_hit     = 1'b0;
    w_dup     = 1'b0;
    w_last    = '0;
    for (int s = 0; s < NPORT; s++) begin
      w_sel[s]  = '0;
      w_gidx[s] = '0;
    end
    if (!rst_i && !flush_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_scan = {1'b0, r_rr_ptr} + (PTRW+1)'(i);
        if (w_scan >= (PTRW+1)'(NUM_REQ)) w_scan = w_scan - (PTRW+1)'(NUM_REQ);
        w_k    = w_scan[PTRW-1:0];
        w_cand = req_indx_i[int'(w_k)*IDXW +: IDXW];
        if (req_valid_i[w_k] && (w_n < 2'd3)) begin
          w_hit = 1'b0;
          for (int s = 0; s < NPORT; s++) begin
            if ((2'(s) < w_n) && (w_gidx[s] == w_cand)) w_hit = 1'b1;
          end
          if (w_hit) begin
            w_dup = 1'b1;
          end else begin
            w_ready[w_k]   = 1'b1;
            w_sel[w_n]     = w_k;
            w_gidx[w_n]    = w_cand;
            w_slot_en[w_n] = 1'b1;
            w_last         = w_k;
            w_n            = w_n + 2'd1;
          end
        end
      end
    end
    w_next_ptr = (w_last == PTRW'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
  end

  assign req_ready_o = w_ready;

  // Register granted requests onto the ROB ports and advance the round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr  <= '0;
      r_en      <= '0;
      r_dup_err <= 1'b0;
      // NOTE: the port data registers are few and must read as zero out of reset, so they are reset like ordinary flops.
      for (int s = 0; s < NPORT; s++) begin
        r_indx[s] <= '0;
        r_pc[s]   <= '0;
        r_val[s]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      if (w_dup) r_dup_err <= 1'b1;
      if (flush_i) begin
        r_en     <= '0;
        r_rr_ptr <= '0;
      end else begin
        r_en <= w_slot_en;
        for (int s = 0; s < NPORT; s++) begin
          if (w_slot_en[s]) begin
            r_indx[s] <= req_indx_i[int'(w_sel[s])*IDXW      +: IDXW];
            r_pc[s]   <= req_pc_i  [int'(w_sel[s])*PC_SIZE   +: PC_SIZE];
            r_val[s]  <= req_val_i [int'(w_sel[s])*WORD_SIZE +: WORD_SIZE];
          end
        end
        if (|w_ready) r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign en_complete_instr0_o = r_en[0];
  assign en_complete_instr1_o = r_en[1];
  assign en_complete_instr2_o = r_en[2];
  assign complete_indx0_o     = r_indx[0];
  assign complete_indx1_o     = r_indx[1];
  assign complete_indx2_o     = r_indx[2];
  assign complete_pc0_o       = r_pc[0];
  assign complete_pc1_o       = r_pc[1];
  assign complete_pc2_o       = r_pc[2];
  assign complete_val0_o      = r_val[0];
  assign complete_val1_o      = r_val[1];
  assign complete_val2_o      = r_val[2];
  assign dup_err_o            = r_dup_err;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Testbench for rob_complete_arbiter: directed scenarios plus randomized
// traffic, compared against a behavioural model of the arbitration rules.
module tb_rob_complete_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int W  = 32;
  localparam int P  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      valid;
  logic [N*IW-1:0]   indx;
  logic [N*P-1:0]    pc;
  logic [N*W-1:0]    val;
  logic [N-1:0]      ready;
  logic              en0, en1, en2;
  logic [IW-1:0]     ix0, ix1, ix2;
  logic [P-1:0]      pc0, pc1, pc2;
  logic [W-1:0]      vl0, vl1, vl2;
  logic              dup;

  always #5 clk = ~clk;

  rob_complete_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .PC_SIZE(P), .ROB_SIZE(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(valid), .req_indx_i(indx), .req_pc_i(pc), .req_val_i(val),
    .req_ready_o(ready),
    .en_complete_instr0_o(en0), .en_complete_instr1_o(en1), .en_complete_instr2_o(en2),
    .complete_indx0_o(ix0), .complete_indx1_o(ix1), .complete_indx2_o(ix2),
    .complete_pc0_o(pc0), .complete_pc1_o(pc1), .complete_pc2_o(pc2),
    .complete_val0_o(vl0), .complete_val1_o(vl1), .complete_val2_o(vl2),
    .dup_err_o(dup)
  );

  int total = 0;
  int bad   = 0;

  // Requester-side stimulus state.
  bit           t_v   [N];
  logic [IW-1:0] t_idx [N];
  logic [P-1:0]  t_pc  [N];
  logic [W-1:0]  t_val [N];

  // Reference model state.
  int           m_ptr;
  bit           m_dup;
  bit           m_en  [3];
  logic [IW-1:0] m_idx [3];
  logic [P-1:0]  m_pc  [3];
  logic [W-1:0]  m_val [3];
  int           m_sel [$];
  logic [N-1:0] obs_ready;

  task automatic model_reset();
    m_ptr = 0;
    m_dup = 1'b0;
    for (int s = 0; s < 3; s++) begin
      m_en[s] = 1'b0; m_idx[s] = '0; m_pc[s] = '0; m_val[s] = '0;
    end
  endtask

  task automatic drive_bus();
    for (int k = 0; k < N; k++) begin
      valid[k]           = t_v[k];
      indx[k*IW +: IW]   = t_idx[k];
      pc[k*P +: P]       = t_pc[k];
      val[k*W +: W]      = t_val[k];
    end
  endtask

  task automatic refresh(input int k, input int c);
    t_v[k]   = 1'b1;
    t_idx[k] = IW'((c * N + k) % 16);
    t_pc[k]  = $urandom;
    t_val[k] = $urandom;
  endtask

  // Round-robin order from the pointer; the first three valid requests whose
  // index is not already among this cycle's grants win, in port order.
  task automatic model_arb(output logic [N-1:0] rdy, output bit d);
    logic [IW-1:0] granted [$];
    rdy = '0;
    d   = 1'b0;
    m_sel.delete();
    if (!flush && !rst) begin
      for (int i = 0; i < N; i++) begin
        int k;
        bit clash;
        k = (m_ptr + i) % N;
        if (t_v[k] && m_sel.size() < 3) begin
          clash = 1'b0;
          foreach (granted[j]) if (granted[j] == t_idx[k]) clash = 1'b1;
          if (clash) d = 1'b1;
          else begin
            rdy[k] = 1'b1;
            m_sel.push_back(k);
            granted.push_back(t_idx[k]);
          end
        end
      end
    end
  endtask

  // One clock cycle: present stimulus, check ready before the edge, advance the
  // model at the edge, then check every registered output after it.
  task automatic step(input string name);
    logic [N-1:0]  exp_rdy;
    bit            d;
    logic [2:0]    o_en;
    logic [IW-1:0] o_ix [3];
    logic [P-1:0]  o_pc [3];
    logic [W-1:0]  o_vl [3];
    drive_bus();
    model_arb(exp_rdy, d);
    #3;
    obs_ready = ready;
    total++;
    if (ready !== exp_rdy) begin
      bad++;
      $display("FAIL %s ready: got %b want %b", name, ready, exp_rdy);
    end
    @(posedge clk);
    if (d) m_dup = 1'b1;
    if (flush) begin
      for (int s = 0; s < 3; s++) m_en[s] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        m_en[s] = (s < m_sel.size());
        if (m_en[s]) begin
          m_idx[s] = t_idx[m_sel[s]];
          m_pc[s]  = t_pc[m_sel[s]];
          m_val[s] = t_val[m_sel[s]];
        end
      end
      if (m_sel.size() > 0) m_ptr = (m_sel[m_sel.size()-1] + 1) % N;
    end
    #1;
    o_en = {en2, en1, en0};
    o_ix = '{ix0, ix1, ix2};
    o_pc = '{pc0, pc1, pc2};
    o_vl = '{vl0, vl1, vl2};
    for (int s = 0; s < 3; s++) begin
      total++;
      if (o_en[s] !== m_en[s]) begin
        bad++;
        $display("FAIL %s port%0d en: got %b want %b", name, s, o_en[s], m_en[s]);
      end
      total++;
      if (o_ix[s] !== m_idx[s] || o_pc[s] !== m_pc[s] || o_vl[s] !== m_val[s]) begin
        bad++;
        $display("FAIL %s port%0d data: got idx=%0d pc=%h val=%h want idx=%0d pc=%h val=%h",
                 name, s, o_ix[s], o_pc[s], o_vl[s], m_idx[s], m_pc[s], m_val[s]);
      end
    end
    total++;
    if (dup !== m_dup) begin
      bad++;
      $display("FAIL %s dup_err: got %b want %b", name, dup, m_dup);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < N; k++) refresh(k, 0);
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready !== '0 || {en0, en1, en2} !== 3'b000 || dup !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b en=%b%b%b dup=%b want 0000 000 0", ready, en2, en1, en0, dup);
    end
    total++;
    if (ix0 !== '0 || pc1 !== '0 || vl2 !== '0) begin
      bad++;
      $display("FAIL reset_data: got ix0=%0d pc1=%h vl2=%h want 0", ix0, pc1, vl2);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_contention();
    for (int k = 0; k < N; k++) begin
      t_v[k] = 1'b1; t_idx[k] = IW'(k + 1); t_pc[k] = P'(32'h1000 + k * 4); t_val[k] = W'(32'hA + k);
    end
    step("contend_c0");
    total++;
    if (obs_ready !== 4'b0111) begin
      bad++; $display("FAIL contend_ready0: got %b want 0111", obs_ready);
    end
    total++;
    if ({en2, en1, en0} !== 3'b111 || ix0 !== 4'd1 || ix1 !== 4'd2 || ix2 !== 4'd3 ||
        vl0 !== 32'hA || vl1 !== 32'hB || vl2 !== 32'hC) begin
      bad++;
      $display("FAIL contend_ports0: got idx %0d/%0d/%0d val %h/%h/%h want 1/2/3 A/B/C", ix0, ix1, ix2, vl0, vl1, vl2);
    end
    for (int k = 0; k < 3; k++) t_v[k] = 1'b0;
    step("contend_c1");
    total++;
    if (obs_ready !== 4'b1000) begin
      bad++; $display("FAIL contend_ready1: got %b want 1000", obs_ready);
    end
    total++;
    if ({en2, en1, en0} !== 3'b001 || ix0 !== 4'd4 || vl0 !== 32'hD) begin
      bad++; $display("FAIL contend_ports1: got en=%b%b%b idx=%0d val=%h want 001 4 D", en2, en1, en0, ix0, vl0);
    end
    for (int k = 0; k < N; k++) refresh(k, 1);
    step("contend_ptr");
    total++;
    if (obs_ready !== 4'b0111) begin
      bad++; $display("FAIL contend_ptr0: got %b want 0111", obs_ready);
    end
  endtask

  task automatic test_rotation();
    int cnt [N];
    int gap [N];
    int maxgap;
    maxgap = 0;
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0; gap[k] = 0;
      if (obs_ready[k]) refresh(k, 2);
    end
    for (int c = 0; c < 8; c++) begin
      step("rotate");
      for (int k = 0; k < N; k++) begin
        if (obs_ready[k]) begin
          cnt[k]++; gap[k] = 0; refresh(k, c + 3);
        end else begin
          gap[k]++;
          if (gap[k] > maxgap) maxgap = gap[k];
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (cnt[k] != 6) begin
        bad++; $display("FAIL rotate_count req%0d: got %0d want 6", k, cnt[k]);
      end
    end
    total++;
    if (maxgap > 1) begin
      bad++; $display("FAIL rotate_gap: got %0d want <=1", maxgap);
    end
  endtask

  task automatic test_dup();
    flush = 1'b1;
    for (int k = 0; k < N; k++) t_v[k] = 1'b0;
    step("dup_flush");
    flush = 1'b0;
    t_v[0] = 1'b1; t_idx[0] = 4'd5; t_val[0] = 32'h50; t_pc[0] = 32'h200;
    t_v[1] = 1'b1; t_idx[1] = 4'd5; t_val[1] = 32'h51; t_pc[1] = 32'h204;
    t_v[2] = 1'b1; t_idx[2] = 4'd6; t_val[2] = 32'h52; t_pc[2] = 32'h208;
    step("dup_c0");
    total++;
    if (obs_ready !== 4'b0101) begin
      bad++; $display("FAIL dup_ready: got %b want 0101", obs_ready);
    end
    total++;
    if ({en2, en1, en0} !== 3'b011 || ix0 !== 4'd5 || vl0 !== 32'h50 || ix1 !== 4'd6 || vl1 !== 32'h52 || dup !== 1'b1) begin
      bad++;
      $display("FAIL dup_ports: got en=%b%b%b idx=%0d/%0d val=%h/%h dup=%b want 011 5/6 50/52 1",
               en2, en1, en0, ix0, ix1, vl0, vl1, dup);
    end
    for (int k = 0; k < N; k++) t_v[k] = 1'b0;
    repeat (10) step("dup_idle");
    total++;
    if (dup !== 1'b1 || {en2, en1, en0} !== 3'b000) begin
      bad++; $display("FAIL dup_sticky: got dup=%b en=%b%b%b want 1 000", dup, en2, en1, en0);
    end
  endtask

  task automatic test_flush();
    t_v[0] = 1'b1; t_idx[0] = 4'd7; t_pc[0] = 32'h300; t_val[0] = 32'h70;
    step("flush_n");
    total++;
    if (obs_ready !== 4'b0001 || en0 !== 1'b1) begin
      bad++; $display("FAIL flush_grant0: got ready=%b en0=%b want 0001 1", obs_ready, en0);
    end
    t_v[0] = 1'b0;
    t_v[1] = 1'b1; t_idx[1] = 4'd8; t_pc[1] = 32'h304; t_val[1] = 32'h80;
    flush = 1'b1;
    step("flush_n1");
    total++;
    if (obs_ready !== 4'b0000 || {en2, en1, en0} !== 3'b000) begin
      bad++; $display("FAIL flush_drop: got ready=%b en=%b%b%b want 0000 000", obs_ready, en2, en1, en0);
    end
    flush = 1'b0;
    step("flush_after");
    total++;
    if (obs_ready !== 4'b0010 || en0 !== 1'b1 || ix0 !== 4'd8) begin
      bad++; $display("FAIL flush_resume: got ready=%b en0=%b idx=%0d want 0010 1 8", obs_ready, en0, ix0);
    end
    t_v[1] = 1'b0;
  endtask

  task automatic test_single();
    for (int k = 0; k < N; k++) t_v[k] = 1'b0;
    t_v[2] = 1'b1; t_idx[2] = 4'd15; t_pc[2] = 32'h100; t_val[2] = 32'hF0;
    step("single_c0");
    total++;
    if ({en2, en1, en0} !== 3'b001 || ix0 !== 4'd15 || pc0 !== 32'h100) begin
      bad++; $display("FAIL single_port: got en=%b%b%b idx=%0d pc=%h want 001 15 100", en2, en1, en0, ix0, pc0);
    end
    t_v[2] = 1'b0;
    step("single_c1");
    total++;
    if ({en2, en1, en0} !== 3'b000) begin
      bad++; $display("FAIL single_pulse: got en=%b%b%b want 000", en2, en1, en0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      step("random");
      for (int k = 0; k < N; k++) begin
        if (!t_v[k] || obs_ready[k]) begin
          t_v[k]   = ($urandom_range(0, 3) != 0);
          t_idx[k] = {2'($urandom_range(0, 3)), 2'(k)};
          t_pc[k]  = $urandom;
          t_val[k] = $urandom;
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < N; k++) refresh(k, 5);
    step("pre_reset");
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (ready !== '0 || {en2, en1, en0} !== 3'b000 || dup !== 1'b0 ||
        ix0 !== '0 || pc0 !== '0 || vl0 !== '0 || ix2 !== '0) begin
      bad++;
      $display("FAIL reset_async: got ready=%b en=%b%b%b dup=%b idx0=%0d want 0000 000 0 0",
               ready, en2, en1, en0, dup, ix0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) refresh(k, 6);
    step("post_reset");
    total++;
    if (obs_ready !== 4'b0111) begin
      bad++; $display("FAIL reset_resume: got %b want 0111", obs_ready);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      t_v[k] = 1'b0; t_idx[k] = '0; t_pc[k] = '0; t_val[k] = '0;
    end
    obs_ready = '0;
    model_reset();
    test_reset();
    test_contention();
    test_rotation();
    test_dup();
    test_flush();
    test_single();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_complete_arbiter.md
# rob_complete_arbiter

Arbitrates result writebacks from NUM_REQ functional-unit requesters onto the reorder buffer's three completion ports (en_complete_instr0..2, complete_indx0..2, complete_pc0..2, complete_val0..2). Up to three requests are granted per cycle under rotating round-robin priority, which bounds starvation. Each granted request is presented on a registered ROB port one cycle after acceptance. The block sits between the execution units' result buses and the reorder buffer.

## Interface
- NUM_REQ, 4, number of result requesters (2..8)
- WORD_SIZE, 32, result value width
- PC_SIZE, 32, PC width
- ROB_SIZE, 16, ROB depth; IDXW = $clog2(ROB_SIZE)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- flush_i  input  1  pipeline flush; drops pending and in-flight completions
- req_valid_i  input  NUM_REQ  requester k holds a result
- req_indx_i  input  NUM_REQ*IDXW  ROB index, slice k = [k*IDXW +: IDXW]
- req_pc_i  input  NUM_REQ*PC_SIZE  instruction PC, slice k
- req_val_i  input  NUM_REQ*WORD_SIZE  result value, slice k
- req_ready_o  output  NUM_REQ  grant for requester k this cycle (combinational)
- en_complete_instr0_o / 1_o / 2_o  output  1 each  ROB completion enables
- complete_indx0_o / 1_o / 2_o  output  IDXW each  ROB index
- complete_pc0_o / 1_o / 2_o  output  PC_SIZE each  PC
- complete_val0_o / 1_o / 2_o  output  WORD_SIZE each  value
- dup_err_o  output  1  sticky: two valid requests carried the same ROB index in one cycle

## Operation
- State: rr_ptr (clog2(NUM_REQ) bits), three output port registers, dup_err_o.
- Each cycle, requesters are scanned in order rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
- The first three requesters with req_valid_i=1 are granted: req_ready_o[k]=1.
- Grants fill ports in scan order: the first grant goes to port 0, the second to port 1, the third to port 2.
- Ports without a grant register en_complete=0. Their indx/pc/val hold their previous values.
- A transfer occurs when req_valid_i[k] & req_ready_o[k] at the rising edge. The requester drops or replaces its data the next cycle.
- A requester with valid=1 and ready=0 holds indx/pc/val stable until granted.
- Duplicate index: if a candidate's req_indx_i equals that of an already-granted request in the same cycle:
  - the candidate is not granted and the scan continues;
  - dup_err_o sets at the edge and stays set until reset.
- rr_ptr update: if at least one grant occurred, rr_ptr ← (index of last granted requester + 1) mod NUM_REQ. With no grants, rr_ptr holds.
- Starvation bound: with NUM_REQ ≤ 6, a valid request is granted within 2 cycles of asserting valid, absent duplicate suppression.
- flush_i=1:
  - req_ready_o forced to all 0;
  - at the edge, all en_complete registers clear to 0 and rr_ptr resets to 0;
  - dup_err_o is unaffected.
- Combinational paths: req_valid_i/req_indx_i → req_ready_o, and flush_i → req_ready_o. There is no combinational path from inputs to any ROB port output.

## Timing
- Latency: accepted at edge N → en_complete_instrX_o=1 with its data during cycle N+1 (the ROB samples it at edge N+1).
- Each en_complete pulse lasts exactly one cycle per accepted request.
- Throughput: 3 completions per cycle sustained.
- Reset (asynchronous, rst_i=1):
  - en_complete_instr0..2_o = 0;
  - complete_indx/pc/val 0..2 = 0;
  - rr_ptr = 0;
  - dup_err_o = 0;
  - req_ready_o = 0 while rst_i=1.
- Reset mid-transfer: a request granted in the cycle reset asserts is lost, and its port shows en=0. Requesters re-present after reset.
- First edge after rst_i deasserts: normal arbitration with rr_ptr=0.
- flush_i and rst_i together: reset dominates.
- No valid requests: all ports en=0 next cycle, and rr_ptr is unchanged.

## Test plan
- Reset: assert rst_i mid-cycle with all four requests valid → all en_complete=0, ready=0, dup_err_o=0 immediately (asynchronous).
- Four-way contention, rr_ptr=0, indices 1/2/3/4, vals 0xA/0xB/0xC/0xD → cycle N: ready=0111; N+1: ports 0/1/2 = idx 1/2/3, vals 0xA/0xB/0xC. Req3 held → N+1: ready=1000; N+2: port0 = idx 4, val 0xD; rr_ptr=0.
- Round-robin rotation: hold all four valid with fresh data every grant for 8 cycles → each requester granted 6 times, and no requester goes more than 1 cycle ungranted.
- Duplicate index: req0 and req1 both idx 5, req2 idx 6 → ready=0101; ports idx 5 (req0) and idx 6; dup_err_o=1 next cycle and remains 1 after 10 idle cycles.
- Flush: grant req0 at edge N, assert flush_i during cycle N+1 with req1 valid → ready=0 during flush; port outputs all en=0 at N+2; rr_ptr=0; req1 granted the first cycle after flush_i drops.
- Single requester with pc=0x100, idx 15 (wrap index) → port0 en=1, indx=15, pc=0x100 for exactly one cycle; ports 1 and 2 en=0.
